// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM-download staging block.
// Holds the FIFO entry layout, the write FSM state encoding and the FIFO depth.
package jtframe_dwnld_pkg;

   localparam int DWNLD_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      GAP
   } dwnld_st_t;

   typedef struct packed {
      logic [1:0]  ba;
      logic [21:0] addr;
      logic [7:0]  data;
      logic        odd;
   } dwnld_entry_t;

   // Active-low byte enable: an odd byte offset lands in the high byte lane.
   function automatic logic [1:0] lane_mask(input logic odd);
      return odd ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/jtframe_dwnld_pack_if.sv
// SDRAM programming port between the download packer (master) and the SDRAM
// controller (slave). prog_we is held by the master until prog_rdy comes back.
interface jtframe_dwnld_pack_if;

   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic [1:0]  prog_ba;
   logic        prog_we;
   logic        prog_rdy;

   modport master (
      output prog_addr,
      output prog_data,
      output prog_mask,
      output prog_ba,
      output prog_we,
      input  prog_rdy
   );

   modport slave (
      input  prog_addr,
      input  prog_data,
      input  prog_mask,
      input  prog_ba,
      input  prog_we,
      output prog_rdy
   );

endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Four-entry synchronous FIFO of download entries. The head entry is visible
// combinationally on dout; a push into a full FIFO is only accepted when a pop
// happens in the same cycle, so occupancy then stays unchanged.
module jtframe_dwnld_fifo
   import jtframe_dwnld_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  dwnld_entry_t din,
   output dwnld_entry_t dout,
   output logic         full,
   output logic         empty
);

   logic [1:0]   wr_ptr;
   logic [1:0]   rd_ptr;
   logic [2:0]   count;
   logic         do_push;
   logic         do_pop;
   dwnld_entry_t mem [DWNLD_FIFO_DEPTH];

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == 3'(DWNLD_FIFO_DEPTH));
   assign empty   = (count == 3'd0);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// ROM-download staging block: maps each ioctl byte to an SDRAM bank and word
// address, buffers it in a small FIFO and writes it out one masked byte at a
// time over the prog_* handshake. dwnld_busy holds game reset until drained.
// Optional feature macro: JTFRAME_DWNLD_PROM_EN diverts bytes at or above
// PROM_START to a PROM write port instead of SDRAM.
module jtframe_dwnld_pack
   import jtframe_dwnld_pkg::*;
#(
   parameter logic [24:0] BA1_START  = 25'h10_0000,
   parameter logic [24:0] BA2_START  = 25'h20_0000,
   parameter logic [24:0] BA3_START  = 25'h30_0000
`ifdef JTFRAME_DWNLD_PROM_EN
   ,
   parameter logic [24:0] PROM_START = 25'h3F_0000,
   parameter int          PROMW      = 10
`endif
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  downloading,
   input  logic [24:0]           ioctl_addr,
   input  logic [7:0]            ioctl_data,
   input  logic                  ioctl_wr,
   jtframe_dwnld_pack_if.master  prog,
   output logic                  dwnld_busy,
   output logic                  overflow
`ifdef JTFRAME_DWNLD_PROM_EN
   ,
   output logic [PROMW-1:0]      prom_addr,
   output logic                  prom_we
`endif
);

   dwnld_st_t    state;
   dwnld_st_t    state_nxt;
   dwnld_entry_t entry_in;
   dwnld_entry_t head;
   logic [1:0]   bank;
   logic [22:0]  bank_start;
   logic [22:0]  offset;
   logic         is_prom;
   logic         wr_en;
   logic         pop;
   logic         full;
   logic         empty;
   logic         drop;
   logic         downloading_d;

`ifdef JTFRAME_DWNLD_PROM_EN
   logic [PROMW-1:0] prom_off;

   assign is_prom  = (ioctl_addr >= PROM_START);
   assign prom_off = ioctl_addr[PROMW-1:0] - PROM_START[PROMW-1:0];
`else
   assign is_prom  = 1'b0;
`endif

   // Bank decode, highest bank first; only the low 23 offset bits are ever used.
   always_comb begin
      bank       = 2'd0;
      bank_start = 23'd0;
      if (ioctl_addr >= BA3_START) begin
         bank       = 2'd3;
         bank_start = BA3_START[22:0];
      end else if (ioctl_addr >= BA2_START) begin
         bank       = 2'd2;
         bank_start = BA2_START[22:0];
      end else if (ioctl_addr >= BA1_START) begin
         bank       = 2'd1;
         bank_start = BA1_START[22:0];
      end
      offset        = ioctl_addr[22:0] - bank_start;
      entry_in.ba   = bank;
      entry_in.addr = offset[22:1];
      entry_in.data = ioctl_data;
      entry_in.odd  = offset[0];
   end

   assign wr_en      = ioctl_wr & downloading & ~is_prom;
   assign drop       = wr_en & full & ~pop;
   assign dwnld_busy = downloading | ~empty | (state != IDLE);

   jtframe_dwnld_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop),
      .din   (entry_in),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: pop in IDLE, wait for acceptance in WRITE, rest in GAP.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (prog.prog_rdy) state_nxt = GAP;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SDRAM port registers: load on pop, hold through WRITE, drop we on rdy.
   always_ff @(posedge clk) begin
      if (rst) begin
         prog.prog_we   <= 1'b0;
         prog.prog_addr <= 22'd0;
         prog.prog_data <= 16'd0;
         prog.prog_mask <= 2'b11;
         prog.prog_ba   <= 2'd0;
      end else begin
         if (pop) begin
            prog.prog_we   <= 1'b1;
            prog.prog_addr <= head.addr;
            prog.prog_data <= {head.data, head.data};
            prog.prog_mask <= lane_mask(head.odd);
            prog.prog_ba   <= head.ba;
         end else if (state == WRITE && prog.prog_rdy) begin
            prog.prog_we   <= 1'b0;
         end
      end
   end

   // Sticky overflow: set on a dropped byte, cleared when a new download starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         downloading_d <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         downloading_d <= downloading;
         if (drop)
            overflow <= 1'b1;
         else if (downloading && !downloading_d)
            overflow <= 1'b0;
      end
   end

`ifdef JTFRAME_DWNLD_PROM_EN
   // PROM bypass: one-cycle write pulse with the address relative to PROM_START.
   always_ff @(posedge clk) begin
      if (rst) begin
         prom_we   <= 1'b0;
         prom_addr <= '0;
      end else begin
         prom_we <= ioctl_wr & downloading & is_prom;
         if (ioctl_wr && downloading && is_prom) prom_addr <= prom_off;
      end
   end
`endif

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed self-checking bench for jtframe_dwnld_pack. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// Optional feature macro: JTFRAME_DWNLD_PROM_EN enables the PROM bypass checks.
module tb_jtframe_dwnld_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        downloading;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        dwnld_busy;
   logic        overflow;
   int          checks = 0;
   int          errors = 0;
`ifdef JTFRAME_DWNLD_PROM_EN
   logic [9:0]  prom_addr;
   logic        prom_we;
`endif

   jtframe_dwnld_pack_if prog_bus ();

   jtframe_dwnld_pack dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .ioctl_wr    (ioctl_wr),
      .prog        (prog_bus),
      .dwnld_busy  (dwnld_busy),
      .overflow    (overflow)
`ifdef JTFRAME_DWNLD_PROM_EN
      ,
      .prom_addr   (prom_addr),
      .prom_we     (prom_we)
`endif
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One ioctl byte strobe lasting a single cycle.
   task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
      ioctl_addr = addr;
      ioctl_data = data;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   // Bounded wait for a write request, then check that one arrived.
   task automatic waitWe(input string tag, input int budget);
      for (int i = 0; i < budget && prog_bus.prog_we !== 1'b1; i++) tick();
      checkOutput(tag, 32'(prog_bus.prog_we), 32'd1);
   endtask

   task automatic pulseRdy();
      prog_bus.prog_rdy = 1'b1;
      tick();
      prog_bus.prog_rdy = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       saw_we;

      rst               = 1'b1;
      downloading       = 1'b0;
      ioctl_addr        = '0;
      ioctl_data        = '0;
      ioctl_wr          = 1'b0;
      prog_bus.prog_rdy = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      checkOutput("rst_we",   32'(prog_bus.prog_we),   32'd0);
      checkOutput("rst_addr", 32'(prog_bus.prog_addr), 32'd0);
      checkOutput("rst_data", 32'(prog_bus.prog_data), 32'd0);
      checkOutput("rst_mask", 32'(prog_bus.prog_mask), 32'd3);
      checkOutput("rst_ba",   32'(prog_bus.prog_ba),   32'd0);
      checkOutput("rst_busy", 32'(dwnld_busy),         32'd0);
      checkOutput("rst_ovf",  32'(overflow),           32'd0);

      // Single odd byte, rdy two cycles after we
      $display("[TB] single byte");
      downloading = 1'b1;
      tick();
      tick();
      applyStimulus(25'h000003, 8'hA5);
      checkOutput("lat_n1_we", 32'(prog_bus.prog_we), 32'd0);
      tick();
      checkOutput("lat_n2_we", 32'(prog_bus.prog_we),   32'd1);
      checkOutput("b0_ba",     32'(prog_bus.prog_ba),   32'd0);
      checkOutput("b0_addr",   32'(prog_bus.prog_addr), 32'd1);
      checkOutput("b0_data",   32'(prog_bus.prog_data), 32'hA5A5);
      checkOutput("b0_mask",   32'(prog_bus.prog_mask), 32'd1);
      tick();
      checkOutput("hold_we1", 32'(prog_bus.prog_we), 32'd1);
      tick();
      checkOutput("hold_we2", 32'(prog_bus.prog_we), 32'd1);
      pulseRdy();
      checkOutput("drop_we",  32'(prog_bus.prog_we), 32'd0);
      checkOutput("gap_busy", 32'(dwnld_busy),       32'd1);
      repeat (3) tick();

      // Bank 0 / bank 1 boundary
      $display("[TB] bank boundary");
      applyStimulus(25'h0FFFFF, 8'h11);
      tick();
      checkOutput("bnd0_we",   32'(prog_bus.prog_we),   32'd1);
      checkOutput("bnd0_ba",   32'(prog_bus.prog_ba),   32'd0);
      checkOutput("bnd0_addr", 32'(prog_bus.prog_addr), 32'h7FFFF);
      checkOutput("bnd0_mask", 32'(prog_bus.prog_mask), 32'd1);
      checkOutput("bnd0_data", 32'(prog_bus.prog_data), 32'h1111);
      pulseRdy();
      repeat (4) tick();
      applyStimulus(25'h100000, 8'h22);
      tick();
      checkOutput("bnd1_we",   32'(prog_bus.prog_we),   32'd1);
      checkOutput("bnd1_ba",   32'(prog_bus.prog_ba),   32'd1);
      checkOutput("bnd1_addr", 32'(prog_bus.prog_addr), 32'd0);
      checkOutput("bnd1_mask", 32'(prog_bus.prog_mask), 32'd2);
      checkOutput("bnd1_data", 32'(prog_bus.prog_data), 32'h2222);
      pulseRdy();
      repeat (3) tick();

      // SDRAM stall: six bytes at 8-cycle spacing, the sixth is dropped
      $display("[TB] overflow");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(25'h200010 + 25'(i), 8'h10 + 8'(i));
         repeat (7) tick();
      end
      repeat (52) tick();
      checkOutput("ovf_set",    32'(overflow),           32'd1);
      checkOutput("ovf_inflt",  32'(prog_bus.prog_data), 32'h1010);
      for (int k = 0; k < 5; k++) begin
         d = 8'h10 + 8'(k);
         waitWe("ovf_wait", 10);
         checkOutput("ovf_data", 32'(prog_bus.prog_data), 32'({d, d}));
         checkOutput("ovf_addr", 32'(prog_bus.prog_addr), 32'((16 + k) >> 1));
         checkOutput("ovf_mask", 32'(prog_bus.prog_mask), (k % 2 == 1) ? 32'd1 : 32'd2);
         checkOutput("ovf_ba",   32'(prog_bus.prog_ba),   32'd2);
         pulseRdy();
      end
      saw_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         saw_we = saw_we | prog_bus.prog_we;
      end
      checkOutput("ovf_no6th", 32'(saw_we), 32'd0);
      downloading = 1'b0;
      tick();
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);
      downloading = 1'b1;
      tick();
      checkOutput("ovf_clear", 32'(overflow), 32'd0);
      tick();

      // downloading falls with three entries queued behind one in flight
      $display("[TB] drain");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(25'h000100 + 25'(i), 8'h40 + 8'(i));
         repeat (7) tick();
      end
      downloading = 1'b0;
      tick();
      checkOutput("drn_busy0", 32'(dwnld_busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         d = 8'h40 + 8'(k);
         waitWe("drn_wait", 10);
         checkOutput("drn_data", 32'(prog_bus.prog_data), 32'({d, d}));
         checkOutput("drn_busy", 32'(dwnld_busy), 32'd1);
         pulseRdy();
      end
      checkOutput("drn_gap_busy",  32'(dwnld_busy), 32'd1);
      tick();
      checkOutput("drn_idle_busy", 32'(dwnld_busy), 32'd0);

      // Reset in the middle of a write with one more entry buffered
      $display("[TB] reset mid-write");
      downloading = 1'b1;
      tick();
      applyStimulus(25'h000200, 8'h77);
      applyStimulus(25'h000202, 8'h78);
      checkOutput("mr_we_pre", 32'(prog_bus.prog_we), 32'd1);
      downloading = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mr_we",   32'(prog_bus.prog_we),   32'd0);
      checkOutput("mr_addr", 32'(prog_bus.prog_addr), 32'd0);
      checkOutput("mr_data", 32'(prog_bus.prog_data), 32'd0);
      checkOutput("mr_mask", 32'(prog_bus.prog_mask), 32'd3);
      checkOutput("mr_ba",   32'(prog_bus.prog_ba),   32'd0);
      checkOutput("mr_busy", 32'(dwnld_busy),         32'd0);
      checkOutput("mr_ovf",  32'(overflow),           32'd0);
      repeat (4) tick();
      checkOutput("mr_fifo_empty", 32'(prog_bus.prog_we), 32'd0);

      // Top of the address map
      downloading = 1'b1;
      tick();
`ifdef JTFRAME_DWNLD_PROM_EN
      $display("[TB] PROM bypass");
      applyStimulus(25'h3F0010, 8'h3C);
      checkOutput("prom_we1",   32'(prom_we),   32'd1);
      checkOutput("prom_addr",  32'(prom_addr), 32'h010);
      tick();
      checkOutput("prom_we0",   32'(prom_we),   32'd0);
      saw_we = prog_bus.prog_we;
      for (int i = 0; i < 6; i++) begin
         tick();
         saw_we = saw_we | prog_bus.prog_we;
      end
      checkOutput("prom_no_prog", 32'(saw_we), 32'd0);
      downloading = 1'b0;
      tick();
      checkOutput("prom_busy", 32'(dwnld_busy), 32'd0);
`else
      $display("[TB] top of bank 3");
      applyStimulus(25'h3F0010, 8'h3C);
      waitWe("b3_wait", 4);
      checkOutput("b3_ba",   32'(prog_bus.prog_ba),   32'd3);
      checkOutput("b3_addr", 32'(prog_bus.prog_addr), 32'h78008);
      checkOutput("b3_mask", 32'(prog_bus.prog_mask), 32'd2);
      checkOutput("b3_data", 32'(prog_bus.prog_data), 32'h3C3C);
      pulseRdy();
      downloading = 1'b0;
      repeat (2) tick();
      checkOutput("b3_busy", 32'(dwnld_busy), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
